// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the rv32i memory-access stage and its lane aligner:
// opcode/exception vector widths and bit positions, load/store funct3
// encodings, the stage FSM state type and a misalignment helper.
package mem_access_pkg;

    localparam int OPCODE_WIDTH    = 8;
    localparam int EXCEPTION_WIDTH = 8;

    // One-hot opcode type bit positions
    localparam int OP_ALU     = 0;
    localparam int OP_ALU_IMM = 1;
    localparam int OP_LOAD    = 2;
    localparam int OP_STORE   = 3;
    localparam int OP_BRANCH  = 4;
    localparam int OP_JUMP    = 5;
    localparam int OP_UPPER   = 6;
    localparam int OP_SYSTEM  = 7;

    // Exception vector bit positions
    localparam int EXC_ILLEGAL_INSTR         = 0;
    localparam int EXC_INSTR_MISALIGNED      = 1;
    localparam int EXC_ECALL                 = 2;
    localparam int EXC_EBREAK                = 3;
    localparam int EXC_LOAD_ADDR_MISALIGNED  = 4;
    localparam int EXC_STORE_ADDR_MISALIGNED = 5;
    localparam int EXC_LOAD_ACCESS_FAULT     = 6;
    localparam int EXC_STORE_ACCESS_FAULT    = 7;

    // Load/store funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mem_state_t;

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] lane);
        case (funct3[1:0])
            2'b01:   return lane[0];
            2'b10:   return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
// Combinational byte-lane helper: builds byte enables and lane-replicated
// store data, and extracts/extends load data from a bus word.
// Ports:
//   funct3      access size/sign
//   lane        address bits [1:0]
//   store_data  register value to be stored
//   load_word   raw word returned by the bus
//   byte_sel    byte enables (shifted within 4 bits, upper lanes drop off)
//   store_word  store data replicated across lanes
//   load_data   aligned, sign/zero-extended load result
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_sel,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicating the store data means whichever lanes are enabled already
    // see the right bytes, so no barrel shifter is needed.
    always_comb begin
        byte_sel   = 4'b1111;
        store_word = store_data;
        case (funct3[1:0])
            2'b00: begin
                byte_sel   = 4'b0001 << lane;
                store_word = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_sel   = 4'b0011 << lane;
                store_word = {2{store_data[15:0]}};
            end
            default: begin
                byte_sel   = 4'b1111;
                store_word = store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = load_word[7:0];
        case (lane)
            2'd0:    ld_byte = load_word[7:0];
            2'd1:    ld_byte = load_word[15:8];
            2'd2:    ld_byte = load_word[23:16];
            default: ld_byte = load_word[31:24];
        endcase
        ld_half = lane[1] ? load_word[31:16] : load_word[15:0];

        load_data = load_word;
        case (funct3)
            F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  load_data = {24'b0, ld_byte};
            F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  load_data = {16'b0, ld_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
// Memory-access stage of the rv32i pipeline. Issues loads/stores on a
// req/ack data bus, formats load data, and forwards rd/pc/exception state to
// writeback while stalling upstream during outstanding transfers.
// Optional macro MISALIGN_TRAP_EN: misaligned loads/stores raise an address
// misaligned exception instead of wrapping into byte lanes.
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   prev_*              execute-stage outputs (address, store data, rd, pc...)
//   prev_clk_en         incoming stage valid
//   prev_stall/flush    downstream stall/flush requests
//   dmem_*              data-memory bus (req/ack handshake)
//   rd, rd_wdata, rd_w_en, rd_valid, opcode_type, exception, funct3, pc
//                       registered results to writeback
//   clk_en              next-stage valid
//   stall, flush        stall/flush towards upstream
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [31:0]                prev_alu_result,
    input  logic [31:0]                prev_rs2_data,
    input  logic [2:0]                 prev_funct3,
    input  logic [OPCODE_WIDTH-1:0]    prev_opcode_type,
    input  logic [EXCEPTION_WIDTH-1:0] prev_exception,
    input  logic [4:0]                 prev_rd,
    input  logic [31:0]                prev_rd_wdata,
    input  logic                       prev_rd_w_en,
    input  logic                       prev_rd_valid,
    input  logic [31:0]                prev_pc,
    input  logic                       prev_clk_en,
    input  logic                       prev_stall,
    input  logic                       prev_flush,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [31:0]                dmem_addr,
    output logic [31:0]                dmem_wdata,
    output logic [3:0]                 dmem_sel,
    input  logic                       dmem_ack,
    input  logic [31:0]                dmem_rdata,
    output logic [4:0]                 rd,
    output logic [31:0]                rd_wdata,
    output logic                       rd_w_en,
    output logic                       rd_valid,
    output logic [OPCODE_WIDTH-1:0]    opcode_type,
    output logic [EXCEPTION_WIDTH-1:0] exception,
    output logic [2:0]                 funct3,
    output logic [31:0]                pc,
    output logic                       clk_en,
    output logic                       stall,
    output logic                       flush
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

    mem_state_t                 state, next_state;
    logic [CNT_W-1:0]           busy_cnt;
    logic                       done_pending;
    logic                       skid_fault;
    logic [31:0]                skid_rdata;
    logic                       kill_pending;

    logic                       is_load, is_store, mem_op, exc_in;
    logic                       trap_misalign, need_bus, issue, complete;
    logic                       timeout_hit, own_stall, mem_done_now, fault_now;
    logic [31:0]                load_now;
    logic [EXCEPTION_WIDTH-1:0] gen_exc, exc_out;
    logic [3:0]                 sel_c;
    logic [31:0]                wdata_c, load_fmt;

    mem_lane_align u_align (
        .funct3     (prev_funct3),
        .lane       (prev_alu_result[1:0]),
        .store_data (prev_rs2_data),
        .load_word  (dmem_rdata),
        .byte_sel   (sel_c),
        .store_word (wdata_c),
        .load_data  (load_fmt)
    );

    assign is_load  = prev_opcode_type[OP_LOAD];
    assign is_store = prev_opcode_type[OP_STORE];
    assign mem_op   = prev_clk_en & ~prev_flush & (is_load | is_store);
    assign exc_in   = |prev_exception;

`ifdef MISALIGN_TRAP_EN
    assign trap_misalign = mem_op & ~exc_in & is_misaligned(prev_funct3, prev_alu_result[1:0]);
`else
    assign trap_misalign = 1'b0;
`endif

    // done_pending marks a transfer that already finished while downstream
    // was stalled, so the still-presented instruction must not re-issue.
    assign need_bus    = mem_op & ~exc_in & ~trap_misalign & ~done_pending;
    assign timeout_hit = (BUS_TIMEOUT != 0) && (state == ST_BUSY) && !dmem_ack
                         && (busy_cnt == CNT_LAST);
    assign complete    = (state == ST_BUSY) & (dmem_ack | timeout_hit);
    // The BUSY term ignores prev_flush: a flushed transfer still runs to ack.
    assign own_stall   = ((state == ST_IDLE) & need_bus) | ((state == ST_BUSY) & ~complete);
    assign stall       = prev_stall | own_stall;
    assign flush       = prev_flush;
    assign issue       = (state == ST_IDLE) & need_bus & ~prev_stall;

    assign mem_done_now = done_pending | complete;
    assign fault_now    = done_pending ? skid_fault : timeout_hit;
    assign load_now     = done_pending ? skid_rdata : load_fmt;

    // Exceptions raised here are ORed onto whatever arrived from upstream.
    always_comb begin
        gen_exc = '0;
        if (mem_done_now && fault_now) begin
            if (is_load) gen_exc[EXC_LOAD_ACCESS_FAULT]  = 1'b1;
            else         gen_exc[EXC_STORE_ACCESS_FAULT] = 1'b1;
        end
        if (trap_misalign) begin
            if (is_load) gen_exc[EXC_LOAD_ADDR_MISALIGNED]  = 1'b1;
            else         gen_exc[EXC_STORE_ADDR_MISALIGNED] = 1'b1;
        end
        exc_out = prev_exception | gen_exc;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (issue)    next_state = ST_BUSY;
            ST_BUSY: if (complete) next_state = ST_IDLE;
            default:               next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Bus registers are loaded at issue and held through BUSY; the counter
    // measures how long we have waited for ack.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_sel   <= '0;
            busy_cnt   <= '0;
        end else if (issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {prev_alu_result[31:2], 2'b00};
            dmem_wdata <= wdata_c;
            dmem_sel   <= sel_c;
            busy_cnt   <= '0;
        end else if (complete) begin
            dmem_req   <= 1'b0;
        end else if (state == ST_BUSY) begin
            busy_cnt   <= busy_cnt + CNT_W'(1);
        end
    end

    // Skid holds a finished transfer's result until downstream releases the
    // stall; kill_pending remembers a flush seen while the bus was busy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done_pending <= 1'b0;
            skid_fault   <= 1'b0;
            skid_rdata   <= '0;
            kill_pending <= 1'b0;
        end else if (!stall) begin
            done_pending <= 1'b0;
            kill_pending <= 1'b0;
        end else begin
            if (complete && prev_stall) begin
                done_pending <= 1'b1;
                skid_rdata   <= load_fmt;
                skid_fault   <= timeout_hit;
            end
            if (((state == ST_BUSY) || done_pending) && prev_flush)
                kill_pending <= 1'b1;
        end
    end

    // Stage registers advance only when nothing stalls; a stall of our own
    // with downstream free inserts a bubble instead.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clk_en      <= 1'b0;
            exception   <= '0;
            rd_w_en     <= 1'b0;
            rd_valid    <= 1'b0;
            rd          <= '0;
            rd_wdata    <= '0;
            pc          <= '0;
            funct3      <= '0;
            opcode_type <= '0;
        end else if (!stall) begin
            clk_en      <= prev_clk_en & ~prev_flush & ~kill_pending;
            exception   <= exc_out;
            rd_w_en     <= prev_rd_w_en & ~(|exc_out);
            rd          <= prev_rd;
            pc          <= prev_pc;
            funct3      <= prev_funct3;
            opcode_type <= prev_opcode_type;
            if (is_load && mem_done_now && !fault_now) begin
                rd_wdata <= load_now;
                rd_valid <= 1'b1;
            end else begin
                rd_wdata <= prev_rd_wdata;
                rd_valid <= prev_rd_valid & ~(is_load & (|exc_out));
            end
        end else if (!prev_stall) begin
            clk_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TIMEOUT = 4;

    logic                       clk = 1'b0;
    logic                       rstn;
    logic [31:0]                prev_alu_result, prev_rs2_data, prev_rd_wdata, prev_pc;
    logic [2:0]                 prev_funct3;
    logic [OPCODE_WIDTH-1:0]    prev_opcode_type;
    logic [EXCEPTION_WIDTH-1:0] prev_exception;
    logic [4:0]                 prev_rd;
    logic                       prev_rd_w_en, prev_rd_valid, prev_clk_en, prev_stall, prev_flush;
    logic                       dmem_req, dmem_we, dmem_ack;
    logic [31:0]                dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]                 dmem_sel;
    logic [4:0]                 rd;
    logic [31:0]                rd_wdata, pc;
    logic                       rd_w_en, rd_valid, clk_en, stall, flush;
    logic [OPCODE_WIDTH-1:0]    opcode_type;
    logic [EXCEPTION_WIDTH-1:0] exception;
    logic [2:0]                 funct3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          lat;
        logic [4:0]  rdn;
        logic [31:0] pcv;
    } txn_t;

    mem_access #(.BUS_TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .prev_alu_result(prev_alu_result), .prev_rs2_data(prev_rs2_data),
        .prev_funct3(prev_funct3), .prev_opcode_type(prev_opcode_type),
        .prev_exception(prev_exception), .prev_rd(prev_rd),
        .prev_rd_wdata(prev_rd_wdata), .prev_rd_w_en(prev_rd_w_en),
        .prev_rd_valid(prev_rd_valid), .prev_pc(prev_pc),
        .prev_clk_en(prev_clk_en), .prev_stall(prev_stall), .prev_flush(prev_flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_sel(dmem_sel), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .rd(rd), .rd_wdata(rd_wdata), .rd_w_en(rd_w_en), .rd_valid(rd_valid),
        .opcode_type(opcode_type), .exception(exception), .funct3(funct3), .pc(pc),
        .clk_en(clk_en), .stall(stall), .flush(flush)
    );

    always #5 clk = ~clk;

    // Reference model: byte-lane rules written as plain arithmetic.
    function automatic logic [3:0] exp_sel(input logic [2:0] f3, input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        case (f3[1:0])
            2'b00:   return 4'((1 << lane) % 16);
            2'b01:   return 4'((3 << lane) % 16);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (f3[1:0])
            2'b00:   return (rs2 % 256) * 32'h0101_0101;
            2'b01:   return (rs2 % 65536) * 32'h0001_0001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int     lane;
        longint v;
        lane = int'(addr % 4);
        case (f3)
            F3_LB, F3_LBU: begin
                v = longint'((word >> (8 * lane)) % 256);
                if (f3 == F3_LB && v >= 128) v = v - 256;
            end
            F3_LH, F3_LHU: begin
                v = longint'((word >> (16 * (lane / 2))) % 65536);
                if (f3 == F3_LH && v >= 32768) v = v - 65536;
            end
            default: v = longint'(word);
        endcase
        return 32'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        prev_alu_result  = '0;
        prev_rs2_data    = '0;
        prev_funct3      = '0;
        prev_opcode_type = '0;
        prev_exception   = '0;
        prev_rd          = '0;
        prev_rd_wdata    = '0;
        prev_rd_w_en     = 1'b0;
        prev_rd_valid    = 1'b0;
        prev_pc          = '0;
        prev_clk_en      = 1'b0;
        prev_stall       = 1'b0;
        prev_flush       = 1'b0;
        dmem_ack         = 1'b0;
        dmem_rdata       = '0;
    endtask

    task automatic drive_mem(input txn_t t);
        prev_clk_en      = 1'b1;
        prev_opcode_type = t.store ? OPCODE_WIDTH'(1 << OP_STORE) : OPCODE_WIDTH'(1 << OP_LOAD);
        prev_funct3      = t.f3;
        prev_alu_result  = t.addr;
        prev_rs2_data    = t.rs2;
        prev_rd          = t.rdn;
        prev_pc          = t.pcv;
        prev_rd_w_en     = !t.store;
        prev_rd_valid    = 1'b0;
        prev_rd_wdata    = $urandom;
        prev_exception   = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        prev_clk_en      = 1'b1;
        prev_opcode_type = OPCODE_WIDTH'(1 << OP_ALU);
        prev_pc          = 32'h0000_1234;
        prev_rd_wdata    = 32'hCAFE_F00D;
        prev_rd_w_en     = 1'b1;
        prev_rd          = 5'd7;
        step();
        step();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %0h exp 0", dmem_req); end
        checks++; if (clk_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_en got %0h exp 0", clk_en); end
        checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc got %h exp 0", pc); end
        checks++; if (rd_wdata !== 32'h0 || rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_rd got %h/%0d exp 0/0", rd_wdata, rd); end
        checks++; if (rd_w_en !== 1'b0 || rd_valid !== 1'b0 || exception !== '0) begin errors++; $display("[TB] FAIL reset_flags got %b%b exc %h exp 00 exc 0", rd_w_en, rd_valid, exception); end
        checks++; if (dmem_sel !== 4'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0 || dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus got sel %h addr %h wd %h we %b exp zeros", dmem_sel, dmem_addr, dmem_wdata, dmem_we); end
        rstn = 1'b1;
        idle_inputs();
        step();
    endtask

    task automatic test_passthrough();
        int ops[6] = '{OP_ALU, OP_ALU_IMM, OP_BRANCH, OP_JUMP, OP_UPPER, OP_SYSTEM};
        for (int i = 0; i < 6; i++) begin
            logic [31:0] wd, pcv;
            logic [4:0]  rdn;
            logic        we, vl;
            wd = $urandom; pcv = $urandom; rdn = 5'($urandom); we = 1'($urandom); vl = 1'($urandom);
            idle_inputs();
            prev_clk_en      = 1'b1;
            prev_opcode_type = OPCODE_WIDTH'(1 << ops[i]);
            prev_rd_wdata    = wd;
            prev_pc          = pcv;
            prev_rd          = rdn;
            prev_rd_w_en     = we;
            prev_rd_valid    = vl;
            #1;
            checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall got %b/%b exp 0/0", stall, dmem_req); end
            step();
            checks++; if (clk_en !== 1'b1 || rd_wdata !== wd || pc !== pcv || rd !== rdn || rd_w_en !== we || rd_valid !== vl)
                begin errors++; $display("[TB] FAIL pass_regs got en %b wd %h pc %h rd %0d we %b v %b exp 1 %h %h %0d %b %b", clk_en, rd_wdata, pc, rd, rd_w_en, rd_valid, wd, pcv, rdn, we, vl); end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_mem_ops();
        txn_t txns[$];
        txn_t t;
        t = '{1'b1, F3_SW,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 3, 5'd0, 32'h0000_4000}; txns.push_back(t);
        t = '{1'b0, F3_LB,  32'h0000_0203, 32'h0, 32'h80FF_FF00, 1, 5'd3, 32'h0000_4004}; txns.push_back(t);
        t = '{1'b0, F3_LBU, 32'h0000_0203, 32'h0, 32'h80FF_FF00, 2, 5'd4, 32'h0000_4008}; txns.push_back(t);
        t = '{1'b0, F3_LH,  32'h0000_0202, 32'h0, 32'h8001_0000, 1, 5'd5, 32'h0000_400C}; txns.push_back(t);
        for (int i = 0; i < 14; i++) begin
            logic [2:0] lf3[5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
            t.store = 1'($urandom);
            t.f3    = t.store ? 3'($urandom_range(0, 2)) : lf3[$urandom_range(0, 4)];
            t.addr  = $urandom;
`ifdef MISALIGN_TRAP_EN
            if (t.f3[1:0] == 2'b01) t.addr = (t.addr / 2) * 2;
            if (t.f3[1:0] == 2'b10) t.addr = (t.addr / 4) * 4;
`endif
            t.rs2   = $urandom;
            t.rdata = $urandom;
            t.lat   = $urandom_range(1, TIMEOUT - 1);
            t.rdn   = 5'($urandom_range(1, 31));
            t.pcv   = $urandom;
            txns.push_back(t);
        end
        foreach (txns[k]) begin
            t = txns[k];
            drive_mem(t);
            #1;
            checks++; if (stall !== 1'b1 || dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL mem_idle_cycle got stall %b req %b exp 1 0", stall, dmem_req); end
            for (int c = 1; c <= t.lat; c++) begin
                step();
                dmem_ack   = (c == t.lat);
                dmem_rdata = (c == t.lat) ? t.rdata : $urandom;
                #1;
                checks++; if (dmem_req !== 1'b1 || dmem_we !== t.store || dmem_addr !== (t.addr / 4) * 4 || dmem_sel !== exp_sel(t.f3, t.addr))
                    begin errors++; $display("[TB] FAIL mem_bus got req %b we %b addr %h sel %b exp 1 %b %h %b", dmem_req, dmem_we, dmem_addr, dmem_sel, t.store, (t.addr / 4) * 4, exp_sel(t.f3, t.addr)); end
                if (t.store) begin
                    checks++; if (dmem_wdata !== exp_wdata(t.f3, t.rs2)) begin errors++; $display("[TB] FAIL mem_wdata got %h exp %h", dmem_wdata, exp_wdata(t.f3, t.rs2)); end
                end
                checks++; if (stall !== (c != t.lat) || clk_en !== 1'b0) begin errors++; $display("[TB] FAIL mem_busy_stall got stall %b clk_en %b exp %b 0", stall, clk_en, c != t.lat); end
            end
            step();
            dmem_ack = 1'b0;
            #1;
            checks++; if (dmem_req !== 1'b0 || clk_en !== 1'b1 || rd !== t.rdn || pc !== t.pcv || exception !== '0)
                begin errors++; $display("[TB] FAIL mem_done got req %b en %b rd %0d pc %h exc %h exp 0 1 %0d %h 0", dmem_req, clk_en, rd, pc, exception, t.rdn, t.pcv); end
            if (t.store) begin
                checks++; if (rd_w_en !== 1'b0) begin errors++; $display("[TB] FAIL store_rd_w_en got %b exp 0", rd_w_en); end
            end else begin
                checks++; if (rd_wdata !== exp_load(t.f3, t.addr, t.rdata) || rd_valid !== 1'b1 || rd_w_en !== 1'b1)
                    begin errors++; $display("[TB] FAIL load_data got %h v %b we %b exp %h 1 1", rd_wdata, rd_valid, rd_w_en, exp_load(t.f3, t.addr, t.rdata)); end
            end
            idle_inputs();
            step();
        end
    endtask

    task automatic test_timeout();
        txn_t t;
        int   req_cycles;
        t = '{1'b0, F3_LW, 32'h0000_0300, 32'h0, 32'h0, 0, 5'd9, 32'h0000_5000};
        drive_mem(t);
        req_cycles = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (dmem_req !== 1'b1) break;
            req_cycles++;
            checks++; if (stall !== (c < TIMEOUT)) begin errors++; $display("[TB] FAIL timeout_stall cycle %0d got %b exp %b", c, stall, c < TIMEOUT); end
        end
        checks++; if (req_cycles != TIMEOUT) begin errors++; $display("[TB] FAIL timeout_req_cycles got %0d exp %0d", req_cycles, TIMEOUT); end
        checks++; if (exception !== EXCEPTION_WIDTH'(1 << EXC_LOAD_ACCESS_FAULT) || rd_w_en !== 1'b0 || clk_en !== 1'b1)
            begin errors++; $display("[TB] FAIL timeout_fault got exc %h we %b en %b exp %h 0 1", exception, rd_w_en, clk_en, EXCEPTION_WIDTH'(1 << EXC_LOAD_ACCESS_FAULT)); end
        idle_inputs();
        step();
    endtask

    task automatic test_flush();
        txn_t t;
        t = '{1'b1, F3_SB, 32'h0000_0401, 32'h0000_00A5, 32'h0, 2, 5'd0, 32'h0000_6000};
        drive_mem(t);
        step();
        prev_flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b1 || dmem_req !== 1'b1 || flush !== 1'b1) begin errors++; $display("[TB] FAIL flush_busy got stall %b req %b flush %b exp 1 1 1", stall, dmem_req, flush); end
        step();
        prev_flush = 1'b0;
        dmem_ack   = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_ack got req %b stall %b exp 1 0", dmem_req, stall); end
        step();
        dmem_ack = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || clk_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_discard got req %b en %b exp 0 0", dmem_req, clk_en); end
        // Flush while idle: no request at all.
        t = '{1'b0, F3_LW, 32'h0000_0500, 32'h0, 32'h0, 1, 5'd2, 32'h0000_6004};
        drive_mem(t);
        prev_flush = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle_stall got %b exp 0", stall); end
        step();
        checks++; if (dmem_req !== 1'b0 || clk_en !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle got req %b en %b exp 0 0", dmem_req, clk_en); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        txn_t t;
        t = '{1'b0, F3_LW, 32'h0000_0600, 32'h0, 32'h0, 3, 5'd1, 32'h0000_7000};
        drive_mem(t);
        step();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_pre got req %b exp 1", dmem_req); end
        rstn = 1'b0;
        step();
        checks++; if (dmem_req !== 1'b0 || clk_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req got req %b en %b exp 0 0", dmem_req, clk_en); end
        rstn = 1'b1;
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        txn_t        t;
        logic [31:0] word;
        word = $urandom;
        t = '{1'b0, F3_LB, $urandom, 32'h0, 32'h0, 1, 5'd11, 32'h0000_8000};
        drive_mem(t);
        step();
        prev_stall = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = word;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL skid_stall got %b exp 1", stall); end
        step();
        dmem_ack   = 1'b0;
        dmem_rdata = ~word;
        #1;
        checks++; if (dmem_req !== 1'b0 || clk_en !== 1'b0) begin errors++; $display("[TB] FAIL skid_hold got req %b en %b exp 0 0", dmem_req, clk_en); end
        step();
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("[TB] FAIL skid_noreissue got req %b stall %b exp 0 1", dmem_req, stall); end
        prev_stall = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL skid_release got %b exp 0", stall); end
        step();
        checks++; if (rd_wdata !== exp_load(F3_LB, t.addr, word) || rd_valid !== 1'b1 || clk_en !== 1'b1 || dmem_req !== 1'b0)
            begin errors++; $display("[TB] FAIL skid_data got %h v %b en %b req %b exp %h 1 1 0", rd_wdata, rd_valid, clk_en, dmem_req, exp_load(F3_LB, t.addr, word)); end
        idle_inputs();
        step();
    endtask

    task automatic test_exception();
        txn_t t;
        t = '{1'b0, F3_LW, 32'h0000_0700, 32'h0, 32'h0, 1, 5'd6, 32'h0000_9000};
        drive_mem(t);
        prev_exception = EXCEPTION_WIDTH'(1 << EXC_ILLEGAL_INSTR);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL exc_stall got %b exp 0", stall); end
        step();
        checks++; if (dmem_req !== 1'b0 || exception !== EXCEPTION_WIDTH'(1 << EXC_ILLEGAL_INSTR) || rd_w_en !== 1'b0 || clk_en !== 1'b1)
            begin errors++; $display("[TB] FAIL exc_pass got req %b exc %h we %b en %b exp 0 %h 0 1", dmem_req, exception, rd_w_en, clk_en, EXCEPTION_WIDTH'(1 << EXC_ILLEGAL_INSTR)); end
        idle_inputs();
        step();
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        txn_t t;
        t = '{1'b0, F3_LW, 32'h0000_0101, 32'h0, 32'h0, 1, 5'd8, 32'h0000_A000};
        drive_mem(t);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mis_ld_stall got %b exp 0", stall); end
        step();
        checks++; if (dmem_req !== 1'b0 || exception !== EXCEPTION_WIDTH'(1 << EXC_LOAD_ADDR_MISALIGNED) || rd_w_en !== 1'b0 || clk_en !== 1'b1)
            begin errors++; $display("[TB] FAIL mis_ld got req %b exc %h we %b en %b exp 0 %h 0 1", dmem_req, exception, rd_w_en, clk_en, EXCEPTION_WIDTH'(1 << EXC_LOAD_ADDR_MISALIGNED)); end
        t = '{1'b1, F3_SH, 32'h0000_0203, 32'h1234, 32'h0, 1, 5'd0, 32'h0000_A004};
        drive_mem(t);
        step();
        checks++; if (dmem_req !== 1'b0 || exception !== EXCEPTION_WIDTH'(1 << EXC_STORE_ADDR_MISALIGNED))
            begin errors++; $display("[TB] FAIL mis_st got req %b exc %h exp 0 %h", dmem_req, exception, EXCEPTION_WIDTH'(1 << EXC_STORE_ADDR_MISALIGNED)); end
        idle_inputs();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_passthrough();
        test_mem_ops();
        test_timeout();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_exception();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
